sayac_llu_arb: RTL and testbench

SAYAC_LLU_ARB -- requirements
Module: sayac_llu_arb

---
 rtl/sayac_llu_arb.sv | 135 +++++++++++++
 tb/tb_sayac_llu_arb.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sayac_llu_arb.sv
// Two-requester front end for a shared logic unit (AND / ones' / two's complement).
// One operation in flight at a time; the winner is chosen round-robin or fixed-priority.
module sayac_llu_arb #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid0,
    input  logic        req_valid1,
    input  logic [1:0]  req_op0,
    input  logic [1:0]  req_op1,
    input  logic [15:0] req_a0,
    input  logic [15:0] req_b0,
    input  logic [15:0] req_a1,
    input  logic [15:0] req_b1,
    output logic        req_ready0,
    output logic        req_ready1,
    output logic        rsp_valid0,
    output logic        rsp_valid1,
    input  logic        rsp_ready0,
    input  logic        rsp_ready1,
    output logic [15:0] rsp_data,
    output logic [15:0] llu_in1,
    output logic [15:0] llu_in2,
    output logic        llu_and,
    output logic        llu_ones,
    output logic        llu_twos,
    input  logic [15:0] llu_out,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        gnt_q, gnt_d;
    logic        rspLive_q, rspLive_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [15:0] rspData_q, rspData_d;

    logic winner;
    logic accept;
    logic rspDone;

    // A lone valid requester wins outright; the pointer only breaks ties.
    always_comb begin
        if (req_valid0 && req_valid1) begin
            winner = RR_EN ? ptr_q : 1'b0;
        end else begin
            winner = !req_valid0;
        end
        accept     = (state_q == IDLE) && (req_valid0 || req_valid1);
        req_ready0 = (state_q == IDLE) && req_valid0 && !winner;
        req_ready1 = (state_q == IDLE) && req_valid1 && winner;
        rspDone    = (state_q == RESP) && rspLive_q && (gnt_q ? rsp_ready1 : rsp_ready0);
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        rspLive_d = rspLive_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        rspData_d = rspData_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EXEC;
                    gnt_d   = winner;
                    op_d    = winner ? req_op1 : req_op0;
                    a_d     = winner ? req_a1 : req_a0;
                    b_d     = winner ? req_b1 : req_b0;
                    if (RR_EN) begin
                        ptr_d = !winner;
                    end
                end
            end
            EXEC: begin
                state_d   = RESP;
                rspData_d = (op_q == 2'b11) ? 16'h0000 : llu_out;
            end
            RESP: begin
                // The captured result is offered one cycle after entering RESP.
                if (!rspLive_q) begin
                    rspLive_d = 1'b1;
                end else if (rspDone) begin
                    rspLive_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            gnt_q     <= 1'b0;
            rspLive_q <= 1'b0;
            op_q      <= 2'b00;
            a_q       <= 16'h0000;
            b_q       <= 16'h0000;
            rspData_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            rspLive_q <= rspLive_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rspData_q <= rspData_d;
        end
    end

    always_comb begin
        busy       = (state_q != IDLE);
        rsp_data   = rspData_q;
        rsp_valid0 = (state_q == RESP) && rspLive_q && !gnt_q;
        rsp_valid1 = (state_q == RESP) && rspLive_q && gnt_q;
        llu_in1    = (state_q == EXEC) ? a_q : 16'h0000;
        llu_in2    = (state_q == EXEC) ? b_q : 16'h0000;
        llu_and    = (state_q == EXEC) && (op_q == 2'b00);
        llu_ones   = (state_q == EXEC) && (op_q == 2'b01);
        llu_twos   = (state_q == EXEC) && (op_q == 2'b10);
    end

endmodule

// File: tb/tb_sayac_llu_arb.sv
// Directed bench for sayac_llu_arb: one round-robin and one fixed-priority instance,
// each driving its own behavioural logic unit.
module tb_sayac_llu_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reqValid0 = 1'b0, reqValid1 = 1'b0;
    logic [1:0]  reqOp0 = 2'b00, reqOp1 = 2'b00;
    logic [15:0] reqA0 = '0, reqB0 = '0, reqA1 = '0, reqB1 = '0;
    logic        rspReady0 = 1'b0, rspReady1 = 1'b0;

    logic        reqReady0, reqReady1, rspValid0, rspValid1, lluAnd, lluOnes, lluTwos, busy;
    logic [15:0] rspData, lluIn1, lluIn2, lluOut;

    logic        d2ReqReady0, d2ReqReady1, d2RspValid0, d2RspValid1, d2LluAnd, d2LluOnes, d2LluTwos, d2Busy;
    logic [15:0] d2RspData, d2LluIn1, d2LluIn2, d2LluOut;

    int checkCount = 0;
    int failCount  = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] lluModel(input logic selAnd, input logic selOnes,
                                             input logic selTwos, input logic [15:0] x,
                                             input logic [15:0] y);
        if (selAnd)  return x & y;
        if (selOnes) return ~x;
        if (selTwos) return 16'h0000 - x;
        return 16'h0000;
    endfunction

    assign lluOut   = lluModel(lluAnd, lluOnes, lluTwos, lluIn1, lluIn2);
    assign d2LluOut = lluModel(d2LluAnd, d2LluOnes, d2LluTwos, d2LluIn1, d2LluIn2);

    sayac_llu_arb #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid0(reqValid0), .req_valid1(reqValid1),
        .req_op0(reqOp0), .req_op1(reqOp1),
        .req_a0(reqA0), .req_b0(reqB0), .req_a1(reqA1), .req_b1(reqB1),
        .req_ready0(reqReady0), .req_ready1(reqReady1),
        .rsp_valid0(rspValid0), .rsp_valid1(rspValid1),
        .rsp_ready0(rspReady0), .rsp_ready1(rspReady1),
        .rsp_data(rspData),
        .llu_in1(lluIn1), .llu_in2(lluIn2),
        .llu_and(lluAnd), .llu_ones(lluOnes), .llu_twos(lluTwos),
        .llu_out(lluOut), .busy(busy)
    );

    sayac_llu_arb #(.RR_EN(1'b0)) dutFixed (
        .clk(clk), .rst(rst),
        .req_valid0(reqValid0), .req_valid1(reqValid1),
        .req_op0(reqOp0), .req_op1(reqOp1),
        .req_a0(reqA0), .req_b0(reqB0), .req_a1(reqA1), .req_b1(reqB1),
        .req_ready0(d2ReqReady0), .req_ready1(d2ReqReady1),
        .rsp_valid0(d2RspValid0), .rsp_valid1(d2RspValid1),
        .rsp_ready0(rspReady0), .rsp_ready1(rspReady1),
        .rsp_data(d2RspData),
        .llu_in1(d2LluIn1), .llu_in2(d2LluIn2),
        .llu_and(d2LluAnd), .llu_ones(d2LluOnes), .llu_twos(d2LluTwos),
        .llu_out(d2LluOut), .busy(d2Busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // One full transaction at minimum latency, checking every phase along the way.
    task automatic applyStimulus(input string tag, input logic id, input logic [1:0] op,
                                 input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] expected);
        if (id) begin
            reqOp1 = op; reqA1 = a; reqB1 = b; reqValid1 = 1'b1;
        end else begin
            reqOp0 = op; reqA0 = a; reqB0 = b; reqValid0 = 1'b1;
        end
        #1;
        checkOutput({tag, "_ready"}, {reqReady1, reqReady0}, id ? 2'b10 : 2'b01);
        tick();
        reqValid0 = 1'b0;
        reqValid1 = 1'b0;
        #1;
        checkOutput({tag, "_exec_busy"}, busy, 1'b1);
        checkOutput({tag, "_exec_sel"}, {lluAnd, lluOnes, lluTwos},
                    {op == 2'b00, op == 2'b01, op == 2'b10});
        checkOutput({tag, "_exec_in1"}, lluIn1, a);
        checkOutput({tag, "_exec_noready"}, {reqReady1, reqReady0}, 2'b00);
        tick();
        checkOutput({tag, "_n1_sel"}, {lluAnd, lluOnes, lluTwos, lluIn1}, 19'h0);
        checkOutput({tag, "_n1_rspvalid"}, {rspValid1, rspValid0}, 2'b00);
        tick();
        checkOutput({tag, "_rspvalid"}, {rspValid1, rspValid0}, id ? 2'b10 : 2'b01);
        checkOutput({tag, "_rspdata"}, rspData, expected);
        if (id) rspReady1 = 1'b1; else rspReady0 = 1'b1;
        tick();
        checkOutput({tag, "_done_busy"}, busy, 1'b0);
        checkOutput({tag, "_done_rspvalid"}, {rspValid1, rspValid0}, 2'b00);
        rspReady0 = 1'b0;
        rspReady1 = 1'b0;
    endtask

    initial begin
        logic g1 [4];
        logic g2 [4];
        int   n1, n2;

        doReset();
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_rspvalid", {rspValid1, rspValid0}, 2'b00);
        checkOutput("rst_rspdata", rspData, 16'h0000);
        checkOutput("rst_llu", {lluAnd, lluOnes, lluTwos, lluIn1, lluIn2}, 35'h0);
        checkOutput("rst_ready_idle", {reqReady1, reqReady0}, 2'b00);

        applyStimulus("and0", 1'b0, 2'b00, 16'h00FF, 16'h0F0F, 16'h000F);
        applyStimulus("ones1", 1'b1, 2'b01, 16'h1234, 16'h0000, 16'hEDCB);
        applyStimulus("twos0_1", 1'b0, 2'b10, 16'h0001, 16'h5555, 16'hFFFF);
        applyStimulus("twos0_0", 1'b0, 2'b10, 16'h0000, 16'h0000, 16'h0000);
        applyStimulus("twos1_8000", 1'b1, 2'b10, 16'h8000, 16'h0000, 16'h8000);
        applyStimulus("rsvd0", 1'b0, 2'b11, 16'hFFFF, 16'hFFFF, 16'h0000);

        // Response stall with both requesters pushing for service.
        reqOp0 = 2'b00; reqA0 = 16'hAAAA; reqB0 = 16'hFFFF; reqValid0 = 1'b1;
        tick();
        reqValid0 = 1'b0;
        tick();
        tick();
        reqValid0 = 1'b1;
        reqValid1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput($sformatf("stall%0d_rspvalid", i), {rspValid1, rspValid0}, 2'b01);
            checkOutput($sformatf("stall%0d_rspdata", i), rspData, 16'hAAAA);
            checkOutput($sformatf("stall%0d_ready", i), {reqReady1, reqReady0}, 2'b00);
            tick();
        end
        reqValid0 = 1'b0;
        reqValid1 = 1'b0;
        rspReady0 = 1'b1;
        tick();
        rspReady0 = 1'b0;
        checkOutput("stall_release_busy", busy, 1'b0);

        // Grant to requester 0 leaves the pointer favouring 1; reset must restore it.
        reqOp0 = 2'b00; reqA0 = 16'h1111; reqB0 = 16'hFFFF; reqValid0 = 1'b1;
        tick();
        reqValid0 = 1'b0;
        #1;
        checkOutput("rstexec_in_exec", lluAnd, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rstexec_busy", busy, 1'b0);
        checkOutput("rstexec_rspvalid", {rspValid1, rspValid0}, 2'b00);
        tick();
        tick();
        checkOutput("rstexec_later_rspvalid", {rspValid1, rspValid0, busy}, 3'b000);
        reqValid0 = 1'b1;
        reqValid1 = 1'b1;
        #1;
        checkOutput("rstexec_grant0", {reqReady1, reqReady0}, 2'b01);
        reqValid0 = 1'b0;
        reqValid1 = 1'b0;

        // Saturated load from reset: alternation vs fixed priority.
        doReset();
        rspReady0 = 1'b1;
        rspReady1 = 1'b1;
        reqValid0 = 1'b1;
        reqValid1 = 1'b1;
        n1 = 0;
        n2 = 0;
        for (int c = 0; c < 40 && (n1 < 4 || n2 < 4); c++) begin
            #1;
            if ((reqReady0 || reqReady1) && n1 < 4) begin
                g1[n1] = reqReady1;
                n1++;
            end
            if ((d2ReqReady0 || d2ReqReady1) && n2 < 4) begin
                g2[n2] = d2ReqReady1;
                n2++;
            end
            tick();
        end
        reqValid0 = 1'b0;
        reqValid1 = 1'b0;
        checkOutput("rr_grant_count", n1, 4);
        checkOutput("fixed_grant_count", n2, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < n1) checkOutput($sformatf("rr_grant%0d", k), g1[k], k[0]);
            if (k < n2) checkOutput($sformatf("fixed_grant%0d", k), g2[k], 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
